sseg_scan_driver: RTL and testbench

Time-multiplexed driver for the Nexys A7 eight-digit common-anode seven-segment display. It holds one hex nibble, decimal point and enable bit per digit, and scans digits at a fixed refresh rate with an anti-ghosting blank interval. New values are double-buffered so they change only at a frame boundary, which prevents tearing. It sits between the application logic (counters, debug registers) and the AN/sseg/DP board pins.

---
 rtl/sseg_pkg.sv | 20 ++
 rtl/sseg_scan_driver_if.sv | 31 +++
 rtl/sseg_scan_driver_seg_decode.sv | 11 +
 rtl/sseg_scan_driver.sv | 99 +++++++++
 tb/tb_sseg_scan_driver.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are active low, bit6 = g ... bit0 = a.
package sseg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef struct packed {
      logic [3:0] hex;
      logic       dp;
      logic       en;
   } digit_t;

endpackage

// File: rtl/sseg_scan_driver_if.sv
// Application-side load bus and board-pin outputs of the scan driver.
// The brightness signal exists only when SSEG_BRIGHTNESS_EN is defined.
interface sseg_scan_driver_if #(parameter int NUM_DIGITS = 8);

   logic                      load;
   logic [4*NUM_DIGITS-1:0]   hex_in;
   logic [NUM_DIGITS-1:0]     dp_in;
   logic [NUM_DIGITS-1:0]     en_in;
`ifdef SSEG_BRIGHTNESS_EN
   logic [3:0]                brightness;
`endif
   logic [NUM_DIGITS-1:0]     AN;
   logic [6:0]                sseg;
   logic                      DP;
   logic                      frame_tick;
   logic                      pending;

   // load is a single-cycle strobe with no ready: the driver always accepts it.
`ifdef SSEG_BRIGHTNESS_EN
   modport master (output load, hex_in, dp_in, en_in, brightness,
                   input  AN, sseg, DP, frame_tick, pending);
   modport slave  (input  load, hex_in, dp_in, en_in, brightness,
                   output AN, sseg, DP, frame_tick, pending);
`else
   modport master (output load, hex_in, dp_in, en_in,
                   input  AN, sseg, DP, frame_tick, pending);
   modport slave  (input  load, hex_in, dp_in, en_in,
                   output AN, sseg, DP, frame_tick, pending);
`endif

endinterface

// File: rtl/sseg_scan_driver_seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_decode
   import sseg_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_TABLE[i_hex];

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed eight-digit seven-segment driver with frame-synchronous
// double buffering. Optional PWM dimming under SSEG_BRIGHTNESS_EN.
module sseg_scan_driver
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000
)(
   input  logic               CLK100MHZ,
   input  logic               CPU_RESETN,
   sseg_scan_driver_if.slave  bus
);

   localparam int SW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int IW = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;

   logic [SW-1:0]         r_slot_cnt;
   logic [IW-1:0]         r_idx;
   digit_t                r_active [NUM_DIGITS];
   digit_t                r_shadow [NUM_DIGITS];
   logic                  r_pending;
   logic [NUM_DIGITS-1:0] r_an;
   logic [6:0]            r_seg;
   logic                  r_dp;
   logic                  r_frame_tick;

   logic                  w_slot_last;
   logic                  w_frame_edge;
   logic                  w_blank;
   digit_t                w_cur;
   logic [6:0]            w_seg;

   assign w_slot_last  = (r_slot_cnt == SW'(DIGIT_CYCLES - 1));
   assign w_frame_edge = w_slot_last && (r_idx == IW'(NUM_DIGITS - 1));
   assign w_cur        = r_active[r_idx];

   // Blank interval at slot start keeps two anodes from overlapping.
`ifdef SSEG_BRIGHTNESS_EN
   assign w_blank = (r_slot_cnt < SW'(BLANK_CYCLES)) || !w_cur.en ||
                    (r_slot_cnt[3:0] > bus.brightness);
`else
   assign w_blank = (r_slot_cnt < SW'(BLANK_CYCLES)) || !w_cur.en;
`endif

   seg_decode u_seg_decode (
      .i_hex (w_cur.hex),
      .o_seg (w_seg)
   );

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_slot_cnt   <= '0;
         r_idx        <= '0;
         r_pending    <= 1'b0;
         for (int k = 0; k < NUM_DIGITS; k++) begin
            r_active[k] <= '0;
            r_shadow[k] <= '0;
         end
         r_an         <= '1;
         r_seg        <= SEG_BLANK;
         r_dp         <= 1'b1;
         r_frame_tick <= 1'b0;
      end else begin
         if (w_slot_last) begin
            r_slot_cnt <= '0;
            r_idx      <= w_frame_edge ? '0 : r_idx + IW'(1);
         end else begin
            r_slot_cnt <= r_slot_cnt + SW'(1);
         end

         r_frame_tick <= w_frame_edge;

         // Old shadow is applied before a coincident load overwrites it.
         if (w_frame_edge && r_pending) begin
            for (int k = 0; k < NUM_DIGITS; k++) r_active[k] <= r_shadow[k];
         end

         if (bus.load) begin
            for (int k = 0; k < NUM_DIGITS; k++)
               r_shadow[k] <= {bus.hex_in[4*k +: 4], bus.dp_in[k], bus.en_in[k]};
            r_pending <= 1'b1;
         end else if (w_frame_edge) begin
            r_pending <= 1'b0;
         end

         r_an  <= w_blank ? '1 : ~(NUM_DIGITS'(1) << r_idx);
         r_seg <= w_blank ? SEG_BLANK : w_seg;
         r_dp  <= w_blank | ~w_cur.dp;
      end
   end

   assign bus.AN         = r_an;
   assign bus.sseg       = r_seg;
   assign bus.DP         = r_dp;
   assign bus.frame_tick = r_frame_tick;
   assign bus.pending    = r_pending;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: randomized loads checked against a frame-level
// reference model. Define SSEG_BRIGHTNESS_EN to exercise the dimming path.
module tb_sseg_scan_driver;

   localparam int ND    = 4;
   localparam int DC    = 20;
   localparam int BC    = 2;
   localparam int FRAME = ND * DC;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   sseg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

   sseg_scan_driver #(
      .NUM_DIGITS   (ND),
      .DIGIT_CYCLES (DC),
      .BLANK_CYCLES (BC)
   ) dut (
      .CLK100MHZ  (clk),
      .CPU_RESETN (rst_n),
      .bus        (bus)
   );

   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: frame position plus active/shadow digit images.
   int           m_n;
   logic [15:0]  m_act_hex, m_sh_hex;
   logic [3:0]   m_act_dp, m_sh_dp, m_act_en, m_sh_en;
   logic         m_pending;
   logic [13:0]  exp_vec;

   localparam logic [13:0] BLANK_VEC = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};

   function automatic logic [13:0] obs();
      return {bus.AN, bus.sseg, bus.DP, bus.frame_tick, bus.pending};
   endfunction

   task automatic model_reset();
      m_n = 0;
      m_act_hex = '0; m_act_dp = '0; m_act_en = '0;
      m_sh_hex  = '0; m_sh_dp  = '0; m_sh_en  = '0;
      m_pending = 1'b0;
      exp_vec   = BLANK_VEC;
   endtask

   // Advance one clock; expected outputs come from the pre-edge frame position.
   task automatic tick();
      int slot, idx;
      logic blank, edge_now;
      logic [3:0] an;
      logic [6:0] seg;
      logic dp;
      @(posedge clk);
      slot  = m_n % DC;
      idx   = m_n / DC;
      blank = (slot < BC) || !m_act_en[idx];
`ifdef SSEG_BRIGHTNESS_EN
      if ((slot % 16) > int'(bus.brightness)) blank = 1'b1;
`endif
      an = 4'hF;
      if (!blank) an[idx] = 1'b0;
      seg = blank ? 7'h7F : seg_tab[m_act_hex[4*idx +: 4]];
      dp  = blank ? 1'b1 : ~m_act_dp[idx];
      edge_now = (m_n == FRAME - 1);
      if (edge_now && m_pending) begin
         m_act_hex = m_sh_hex; m_act_dp = m_sh_dp; m_act_en = m_sh_en;
      end
      if (bus.load) begin
         m_sh_hex = bus.hex_in; m_sh_dp = bus.dp_in; m_sh_en = bus.en_in;
         m_pending = 1'b1;
      end else if (edge_now) begin
         m_pending = 1'b0;
      end
      exp_vec = {an, seg, dp, edge_now, m_pending};
      m_n = (m_n + 1) % FRAME;
      @(negedge clk);
   endtask

   task automatic set_load(input logic [15:0] h, input logic [3:0] d, input logic [3:0] e);
      bus.hex_in = h; bus.dp_in = d; bus.en_in = e; bus.load = 1'b1;
   endtask

   task automatic test_reset();
      int ticks = 0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (obs() !== exp_vec) begin
         n_fail++; $display("FAIL reset_hold got %h exp %h", obs(), exp_vec);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (bus.frame_tick === 1'b1) ticks++;
         n_cmp++;
         if (obs() !== exp_vec) begin
            n_fail++; $display("FAIL reset_idle cyc %0d got %h exp %h", i, obs(), exp_vec);
         end
      end
      n_cmp++;
      if (ticks !== 2) begin
         n_fail++; $display("FAIL reset_frame_ticks got %0d exp 2", ticks);
      end
   endtask

   task automatic test_load_basic();
      logic seen3 = 1'b0;
      set_load(16'h1234, 4'hF, 4'b0010);
      for (int i = 0; i < 2 * FRAME + 4; i++) begin
         tick();
         bus.load = 1'b0;
         if (bus.AN === 4'b1101 && bus.sseg === 7'b0110000 && bus.DP === 1'b0) seen3 = 1'b1;
         n_cmp++;
         if (obs() !== exp_vec) begin
            n_fail++; $display("FAIL load_basic cyc %0d got %h exp %h", i, obs(), exp_vec);
         end
      end
      n_cmp++;
      if (seen3 !== 1'b1) begin
         n_fail++; $display("FAIL load_basic_digit1 seen %b exp 1", seen3);
      end
   endtask

   task automatic test_two_loads();
      int a_seen = 0;
      for (int k = 0; k < 2 * FRAME && m_n != 5; k++) tick();
      n_cmp++;
      if (m_n != 5) begin
         n_fail++; $display("FAIL two_loads_sync pos %0d exp 5", m_n);
      end
      set_load(16'hAAAA, 4'h0, 4'hF);
      tick();
      bus.load = 1'b0;
      repeat (10) tick();
      set_load(16'hBEEF, 4'h0, 4'hF);
      for (int i = 0; i < 3 * FRAME; i++) begin
         tick();
         bus.load = 1'b0;
         if (bus.AN !== 4'hF && bus.sseg === 7'b0001000) a_seen++;
         n_cmp++;
         if (obs() !== exp_vec) begin
            n_fail++; $display("FAIL two_loads cyc %0d got %h exp %h", i, obs(), exp_vec);
         end
      end
      n_cmp++;
      if (a_seen !== 0) begin
         n_fail++; $display("FAIL two_loads_no_A got %0d exp 0", a_seen);
      end
   endtask

   task automatic test_load_on_edge();
      set_load(16'($urandom), 4'($urandom), 4'hF);
      tick();
      bus.load = 1'b0;
      for (int k = 0; k < 2 * FRAME && m_n != FRAME - 1; k++) tick();
      n_cmp++;
      if (m_n != FRAME - 1) begin
         n_fail++; $display("FAIL edge_sync pos %0d exp %0d", m_n, FRAME - 1);
      end
      set_load(16'($urandom), 4'($urandom), 4'hF);
      tick();
      bus.load = 1'b0;
      n_cmp++;
      if ({bus.frame_tick, bus.pending} !== 2'b11) begin
         n_fail++; $display("FAIL edge_pending tick/pend got %b%b exp 11", bus.frame_tick, bus.pending);
      end
      for (int i = 0; i < 2 * FRAME + 4; i++) begin
         tick();
         n_cmp++;
         if (obs() !== exp_vec) begin
            n_fail++; $display("FAIL load_on_edge cyc %0d got %h exp %h", i, obs(), exp_vec);
         end
      end
   endtask

   task automatic test_enable_mask();
      int bad = 0;
      set_load(16'($urandom), 4'($urandom), 4'b0101);
      for (int i = 0; i < 2 * FRAME + 4; i++) begin
         tick();
         bus.load = 1'b0;
         if (i > FRAME && (bus.AN[1] === 1'b0 || bus.AN[3] === 1'b0)) bad++;
         n_cmp++;
         if (obs() !== exp_vec) begin
            n_fail++; $display("FAIL enable_mask cyc %0d got %h exp %h", i, obs(), exp_vec);
         end
      end
      n_cmp++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL enable_mask_anodes got %0d exp 0", bad);
      end
   endtask

   task automatic test_random_loads();
      for (int it = 0; it < 12; it++) begin
         int gap = $urandom_range(0, 120);
         set_load(16'($urandom), 4'($urandom), 4'($urandom));
         for (int i = 0; i <= gap; i++) begin
            tick();
            bus.load = 1'b0;
            n_cmp++;
            if (obs() !== exp_vec) begin
               n_fail++; $display("FAIL random it %0d cyc %0d got %h exp %h", it, i, obs(), exp_vec);
            end
         end
      end
   endtask

`ifdef SSEG_BRIGHTNESS_EN
   task automatic test_brightness();
      bus.brightness = 4'd3;
      set_load(16'($urandom), 4'($urandom), 4'hF);
      for (int i = 0; i < 2 * FRAME + 4; i++) begin
         tick();
         bus.load = 1'b0;
         n_cmp++;
         if (obs() !== exp_vec) begin
            n_fail++; $display("FAIL brightness cyc %0d got %h exp %h", i, obs(), exp_vec);
         end
      end
      bus.brightness = 4'hF;
   endtask
`endif

   task automatic test_reset_mid();
      int lit = 0;
      set_load(16'h0F0F, 4'hF, 4'hF);
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         bus.load = 1'b0;
      end
      for (int k = 0; k < FRAME && bus.AN === 4'hF; k++) tick();
      n_cmp++;
      if (bus.AN === 4'hF) begin
         n_fail++; $display("FAIL reset_mid_lit AN %h exp not F", bus.AN);
      end
      set_load(16'h5555, 4'h0, 4'hF);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if (obs() !== exp_vec) begin
         n_fail++; $display("FAIL reset_mid_async got %h exp %h", obs(), exp_vec);
      end
      bus.load = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3 * FRAME; i++) begin
         tick();
         if (bus.AN !== 4'hF) lit++;
         n_cmp++;
         if (obs() !== exp_vec) begin
            n_fail++; $display("FAIL reset_mid_after cyc %0d got %h exp %h", i, obs(), exp_vec);
         end
      end
      n_cmp++;
      if (lit !== 0) begin
         n_fail++; $display("FAIL reset_mid_blank lit %0d exp 0", lit);
      end
   endtask

   initial begin
      bus.load = 1'b0; bus.hex_in = '0; bus.dp_in = '0; bus.en_in = '0;
`ifdef SSEG_BRIGHTNESS_EN
      bus.brightness = 4'hF;
`endif
      test_reset();
      test_load_basic();
      test_two_loads();
      test_load_on_edge();
      test_enable_mask();
      test_random_loads();
`ifdef SSEG_BRIGHTNESS_EN
      test_brightness();
`endif
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
